// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm clock datapath: FSM states,
// BCD digit type and the BCD time validity check.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_RING  = 2'd3
  } state_e;

  // Datapath action chosen by the FSM each cycle
  typedef enum logic [2:0] {
    ACT_NONE      = 3'd0,
    ACT_CLEAR     = 3'd1,
    ACT_LOAD      = 3'd2,
    ACT_LOAD_ERR  = 3'd3,
    ACT_DEC       = 3'd4,
    ACT_RING_TICK = 3'd5
  } act_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

  function automatic logic bcd_time_ok(input logic [7:0] mm, input logic [7:0] ss);
    return (mm[7:4] <= DIGIT_MAX) && (mm[3:0] <= DIGIT_MAX) &&
           (ss[7:4] <= SEC_TENS_MAX) && (ss[3:0] <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the borrow chain: subtracts borrow_in, wrapping 0 -> MAX
// and raising borrow_out when it does.
module bcd_digit_dec
  import alarm_pkg::*;
#(
  parameter bcd_t MAX = DIGIT_MAX
) (
  input  logic [3:0] digit_in,
  input  logic       borrow_in,
  output logic [3:0] digit_out,
  output logic       borrow_out
);

  always_comb begin
    digit_out  = digit_in;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit_in == 4'd0) begin
        digit_out  = MAX;
        borrow_out = 1'b1;
      end else begin
        digit_out  = digit_in - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer_bcd.sv
// MM:SS BCD countdown timer: decrements once per tick_1hz in RUN and rings
// for RING_TICKS ticks after reaching 00:00.
module countdown_timer_bcd
  import alarm_pkg::*;
#(
  parameter int RING_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       load,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       running,
  output logic       ring,
  output logic       load_err
);

  localparam logic [7:0] RING_LAST = 8'(RING_TICKS - 1);

  state_e     state_q, state_d;
  act_e       act;
  logic [7:0] mm_q, mm_d, ss_q, ss_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       running_q, running_d, ring_q, ring_d, load_err_q, load_err_d;

  // Borrow chain, digit 0 = seconds units .. digit 3 = minutes tens
  bcd_t [3:0] cur, dec;
  logic [4:0] brw;
  logic       is_zero, is_one, load_ok;

  assign cur    = {mm_q, ss_q};
  assign brw[0] = 1'b1;

  for (genvar g = 0; g < 4; g++) begin : g_dig
    localparam bcd_t MAX = (g == 1) ? SEC_TENS_MAX : DIGIT_MAX;
    bcd_digit_dec #(.MAX(MAX)) u_dig (
      .digit_in  (cur[g]),
      .borrow_in (brw[g]),
      .digit_out (dec[g]),
      .borrow_out(brw[g+1])
    );
  end

  // A borrow out of the top digit only happens when every digit is zero
  assign is_zero = brw[4];
  assign is_one  = (mm_q == 8'h00) && (ss_q == 8'h01);
  assign load_ok = bcd_time_ok(load_mm, load_ss);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mm_q       <= 8'h00;
      ss_q       <= 8'h00;
      tcnt_q     <= 8'h00;
      running_q  <= 1'b0;
      ring_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      tcnt_q     <= tcnt_d;
      running_q  <= running_d;
      ring_q     <= ring_d;
      load_err_q <= load_err_d;
    end
  end

  // Requests only compete where they have an effect; load in RUN falls through
  always_comb begin
    state_d = state_q;
    act     = ACT_NONE;
    if (cancel) begin
      state_d = ST_IDLE;
      act     = ACT_CLEAR;
    end else if (load && state_q != ST_RUN) begin
      if (load_ok) begin
        state_d = (state_q == ST_PAUSE) ? ST_PAUSE : ST_IDLE;
        act     = ACT_LOAD;
      end else begin
        act     = ACT_LOAD_ERR;
      end
    end else if (pause && state_q == ST_RUN) begin
      state_d = ST_PAUSE;
    end else if (start && state_q == ST_PAUSE) begin
      state_d = ST_RUN;
    end else if (start && state_q == ST_IDLE && !is_zero) begin
      state_d = ST_RUN;
    end else if (tick_1hz && state_q == ST_RUN) begin
      act = ACT_DEC;
      if (is_one) state_d = ST_RING;
    end else if (tick_1hz && state_q == ST_RING) begin
      act = ACT_RING_TICK;
      if (tcnt_q == RING_LAST) state_d = ST_IDLE;
    end
  end

  always_comb begin
    mm_d       = mm_q;
    ss_d       = ss_q;
    tcnt_d     = tcnt_q;
    load_err_d = 1'b0;
    case (act)
      ACT_CLEAR: begin
        mm_d   = 8'h00;
        ss_d   = 8'h00;
        tcnt_d = 8'h00;
      end
      ACT_LOAD: begin
        mm_d   = load_mm;
        ss_d   = load_ss;
        tcnt_d = 8'h00;
      end
      ACT_LOAD_ERR: load_err_d = 1'b1;
      ACT_DEC: begin
        {mm_d, ss_d} = dec;
        tcnt_d       = 8'h00;
      end
      ACT_RING_TICK: begin
        tcnt_d = tcnt_q + 8'd1;
        if (state_d == ST_IDLE) begin
          mm_d   = 8'h00;
          ss_d   = 8'h00;
          tcnt_d = 8'h00;
        end
      end
      default: ;
    endcase
    running_d = (state_d == ST_RUN);
    ring_d    = (state_d == ST_RING);
  end

  assign mm       = mm_q;
  assign ss       = ss_q;
  assign running  = running_q;
  assign ring     = ring_q;
  assign load_err = load_err_q;

endmodule
